// File: rtl/pipe_hazard_ctrl.sv
// Stall, flush and forwarding controller for a 5-stage RV32 pipeline.
// It handles load-use bubbles, EX redirects, LSU wait-state freezes with a timeout, and stall-cycle counting.
module pipe_hazard_ctrl #(
    parameter int unsigned LSU_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic             id_rs1_used_i,
    input  logic             id_rs2_used_i,
    input  logic [4:0]       ex_rs1_addr_i,
    input  logic [4:0]       ex_rs2_addr_i,
    input  logic [4:0]       ex_rd_addr_i,
    input  logic             ex_rd_wren_i,
    input  logic             ex_is_load_i,
    input  logic             ex_redirect_i,
    input  logic [4:0]       mem_rd_addr_i,
    input  logic             mem_rd_wren_i,
    input  logic [4:0]       wb_rd_addr_i,
    input  logic             wb_rd_wren_i,
    input  logic             lsu_req_i,
    input  logic             lsu_ack_i,
    output logic             pc_en_o,
    output logic             if_id_en_o,
    output logic             id_ex_en_o,
    output logic             ex_mem_en_o,
    output logic             mem_wb_en_o,
    output logic             if_id_flush_o,
    output logic             id_ex_flush_o,
    output logic [1:0]       fwd_a_sel_o,
    output logic [1:0]       fwd_b_sel_o,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LSU_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [15:0]      r_wait_cnt;
    logic [15:0]      w_wait_cnt_nxt;
    logic             r_err;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_lsu_stall;
    logic             w_load_use;
    logic             w_release;

    // x0 is hardwired to zero, so it never creates a dependency.
    function automatic logic f_match(input logic [4:0] rs, input logic [4:0] rd, input logic en);
        return en && (rs != 5'd0) && (rs == rd);
    endfunction

    function automatic logic [1:0] f_fwd_sel(input logic [4:0] rs, input logic [4:0] mem_rd,
                                             input logic mem_en, input logic [4:0] wb_rd,
                                             input logic wb_en);
        logic [1:0] sel;
        if (f_match(rs, mem_rd, mem_en)) begin
            sel = 2'b01;
        end else if (f_match(rs, wb_rd, wb_en)) begin
            sel = 2'b10;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    assign w_lsu_stall = lsu_req_i && !lsu_ack_i;
    assign w_load_use  = ex_is_load_i && ex_rd_wren_i &&
                         (f_match(id_rs1_addr_i, ex_rd_addr_i, id_rs1_used_i) ||
                          f_match(id_rs2_addr_i, ex_rd_addr_i, id_rs2_used_i));
    assign w_release   = ((r_state == ST_RUN) && !w_lsu_stall) ||
                         ((r_state == ST_LSU_WAIT) && lsu_ack_i);

    // State and LSU wait counter register
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= 16'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    // Next-state logic; the timeout fires on the edge where the wait count would reach LSU_TIMEOUT
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        case (r_state)
            ST_RUN: begin
                if (w_lsu_stall) begin
                    w_state_nxt    = ST_LSU_WAIT;
                    w_wait_cnt_nxt = 16'd1;
                end else begin
                    w_wait_cnt_nxt = 16'd0;
                end
            end
            ST_LSU_WAIT: begin
                if (lsu_ack_i) begin
                    w_state_nxt    = ST_RUN;
                    w_wait_cnt_nxt = 16'd0;
                end else if (r_wait_cnt >= 16'(LSU_TIMEOUT - 1)) begin
                    w_state_nxt    = ST_ERROR;
                    w_wait_cnt_nxt = r_wait_cnt + 16'd1;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 16'd1;
                end
            end
            ST_ERROR: begin
                w_state_nxt = ST_ERROR;
            end
            default: begin
                w_state_nxt    = ST_RUN;
                w_wait_cnt_nxt = 16'd0;
            end
        endcase
    end

    // Enables, flushes and forwarding selects; everything idles while reset is held
    always_comb begin
        pc_en_o       = 1'b0;
        if_id_en_o    = 1'b0;
        id_ex_en_o    = 1'b0;
        ex_mem_en_o   = 1'b0;
        mem_wb_en_o   = 1'b0;
        if_id_flush_o = 1'b0;
        id_ex_flush_o = 1'b0;
        fwd_a_sel_o   = 2'b00;
        fwd_b_sel_o   = 2'b00;
        if (!reset_ni) begin
            fwd_a_sel_o = 2'b00;
        end else begin
            fwd_a_sel_o = f_fwd_sel(ex_rs1_addr_i, mem_rd_addr_i, mem_rd_wren_i,
                                    wb_rd_addr_i, wb_rd_wren_i);
            fwd_b_sel_o = f_fwd_sel(ex_rs2_addr_i, mem_rd_addr_i, mem_rd_wren_i,
                                    wb_rd_addr_i, wb_rd_wren_i);
            if (!w_release) begin
                pc_en_o = 1'b0;
            end else if (ex_redirect_i) begin
                pc_en_o       = 1'b1;
                if_id_en_o    = 1'b1;
                id_ex_en_o    = 1'b1;
                ex_mem_en_o   = 1'b1;
                mem_wb_en_o   = 1'b1;
                if_id_flush_o = 1'b1;
                id_ex_flush_o = 1'b1;
            end else if (w_load_use) begin
                id_ex_en_o    = 1'b1;
                id_ex_flush_o = 1'b1;
                ex_mem_en_o   = 1'b1;
                mem_wb_en_o   = 1'b1;
            end else begin
                pc_en_o     = 1'b1;
                if_id_en_o  = 1'b1;
                id_ex_en_o  = 1'b1;
                ex_mem_en_o = 1'b1;
                mem_wb_en_o = 1'b1;
            end
        end
    end

    // Sticky error flag and saturating stall-cycle counter
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_err       <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_err <= r_err || (w_state_nxt == ST_ERROR);
            if (!pc_en_o && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
        end
    end

    assign err_o       = r_err;
    assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl, instantiated with a short LSU timeout.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset_ni;
    logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic        id_rs1_used, id_rs2_used, ex_wren, ex_load, ex_redir;
    logic        mem_wren, wb_wren, lsu_req, lsu_ack;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_fl, id_ex_fl;
    logic [1:0]  fwd_a, fwd_b;
    logic        err;
    logic [31:0] stall_cnt;
    logic [6:0]  ctl;

    int n_chk  = 0;
    int n_pass = 0;

    // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush}
    localparam logic [6:0] CTL_RUN    = 7'b11111_00;
    localparam logic [6:0] CTL_FREEZE = 7'b00000_00;
    localparam logic [6:0] CTL_REDIR  = 7'b11111_11;
    localparam logic [6:0] CTL_BUBBLE = 7'b00111_01;

    assign ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_fl, id_ex_fl};

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.LSU_TIMEOUT(4), .CNT_W(32)) dut (
        .clk_i(clk), .reset_ni(reset_ni),
        .id_rs1_addr_i(id_rs1), .id_rs2_addr_i(id_rs2),
        .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used),
        .ex_rs1_addr_i(ex_rs1), .ex_rs2_addr_i(ex_rs2), .ex_rd_addr_i(ex_rd),
        .ex_rd_wren_i(ex_wren), .ex_is_load_i(ex_load), .ex_redirect_i(ex_redir),
        .mem_rd_addr_i(mem_rd), .mem_rd_wren_i(mem_wren),
        .wb_rd_addr_i(wb_rd), .wb_rd_wren_i(wb_wren),
        .lsu_req_i(lsu_req), .lsu_ack_i(lsu_ack),
        .pc_en_o(pc_en), .if_id_en_o(if_id_en), .id_ex_en_o(id_ex_en),
        .ex_mem_en_o(ex_mem_en), .mem_wb_en_o(mem_wb_en),
        .if_id_flush_o(if_id_fl), .id_ex_flush_o(id_ex_fl),
        .fwd_a_sel_o(fwd_a), .fwd_b_sel_o(fwd_b),
        .err_o(err), .stall_cnt_o(stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rs1 = 5'd0; ex_rs2 = 5'd0;
        ex_rd = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0; ex_wren = 1'b0; ex_load = 1'b0;
        ex_redir = 1'b0; mem_wren = 1'b0; wb_wren = 1'b0;
        lsu_req = 1'b0; lsu_ack = 1'b0;
    endtask

    task automatic set_load_use_rs1(input logic [4:0] rd, input logic [4:0] rs, input logic used);
        ex_load = 1'b1; ex_wren = 1'b1; ex_rd = rd; id_rs1 = rs; id_rs1_used = used;
    endtask

    initial begin
        idle_inputs();
        reset_ni = 1'b0;
        ex_rs1 = 5'd7; mem_rd = 5'd7; mem_wren = 1'b1;
        lsu_req = 1'b1;
        #1;
        check("reset_ctl", 32'(ctl), 32'(CTL_FREEZE));
        check("reset_fwd_a", 32'(fwd_a), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_stall", stall_cnt, 32'd0);
        repeat (2) @(posedge clk);
        #2;
        idle_inputs();
        reset_ni = 1'b1;
        #1;
        check("run_ctl", 32'(ctl), 32'(CTL_RUN));

        // Load-use on rs1: one bubble, then free running
        set_load_use_rs1(5'd5, 5'd5, 1'b1);
        #1;
        check("lu_bubble", 32'(ctl), 32'(CTL_BUBBLE));
        tick();
        idle_inputs();
        #1;
        check("lu_after", 32'(ctl), 32'(CTL_RUN));
        check("lu_stall_cnt", stall_cnt, 32'd1);

        // Non-hazards: x0 destination, unused source
        set_load_use_rs1(5'd0, 5'd0, 1'b1);
        #1;
        check("lu_x0", 32'(ctl), 32'(CTL_RUN));
        set_load_use_rs1(5'd5, 5'd5, 1'b0);
        #1;
        check("lu_unused", 32'(ctl), 32'(CTL_RUN));
        id_rs2 = 5'd5; id_rs2_used = 1'b1;
        #1;
        check("lu_rs2", 32'(ctl), 32'(CTL_BUBBLE));
        ex_wren = 1'b0;
        #1;
        check("lu_nowren", 32'(ctl), 32'(CTL_RUN));

        // Redirect beats load-use
        idle_inputs();
        set_load_use_rs1(5'd5, 5'd5, 1'b1);
        ex_redir = 1'b1;
        #1;
        check("redir_over_lu", 32'(ctl), 32'(CTL_REDIR));
        tick();
        idle_inputs();
        #1;
        check("redir_stall_cnt", stall_cnt, 32'd1);

        // Zero-wait LSU access falls through to normal rules
        lsu_req = 1'b1; lsu_ack = 1'b1;
        #1;
        check("lsu_zero_wait", 32'(ctl), 32'(CTL_RUN));

        // Three frozen cycles, redirect held back until the ack cycle
        lsu_ack = 1'b0;
        #1;
        check("lsu_freeze0", 32'(ctl), 32'(CTL_FREEZE));
        tick();
        ex_redir = 1'b1;
        #1;
        check("lsu_freeze_redir", 32'(ctl), 32'(CTL_FREEZE));
        tick();
        check("lsu_freeze2", 32'(ctl), 32'(CTL_FREEZE));
        tick();
        lsu_ack = 1'b1;
        #1;
        check("lsu_ack_redir", 32'(ctl), 32'(CTL_REDIR));
        tick();
        idle_inputs();
        #1;
        check("lsu_back_run", 32'(ctl), 32'(CTL_RUN));
        check("lsu_stall_cnt", stall_cnt, 32'd4);
        check("lsu_no_err", 32'(err), 32'd0);

        // Forwarding priority
        mem_rd = 5'd7; wb_rd = 5'd7; mem_wren = 1'b1; wb_wren = 1'b1;
        ex_rs1 = 5'd7; ex_rs2 = 5'd7;
        #1;
        check("fwd_a_mem", 32'(fwd_a), 32'd1);
        check("fwd_b_mem", 32'(fwd_b), 32'd1);
        mem_wren = 1'b0;
        #1;
        check("fwd_a_wb", 32'(fwd_a), 32'd2);
        ex_rs2 = 5'd3;
        #1;
        check("fwd_b_none", 32'(fwd_b), 32'd0);
        mem_rd = 5'd0; wb_rd = 5'd0; mem_wren = 1'b1; ex_rs1 = 5'd0;
        #1;
        check("fwd_a_x0", 32'(fwd_a), 32'd0);

        // Timeout after 4 frozen cycles, sticky error
        idle_inputs();
        lsu_req = 1'b1;
        repeat (3) tick();
        check("to_before_err", 32'(err), 32'd0);
        tick();
        check("to_err", 32'(err), 32'd1);
        check("to_freeze", 32'(ctl), 32'(CTL_FREEZE));
        lsu_ack = 1'b1; ex_redir = 1'b1;
        #1;
        check("err_ignores_ack", 32'(ctl), 32'(CTL_FREEZE));
        repeat (2) tick();
        check("err_sticky", 32'(err), 32'd1);
        check("err_stall_cnt", stall_cnt, 32'd10);

        // Asynchronous reset clears everything
        #2;
        reset_ni = 1'b0;
        #1;
        check("areset_err", 32'(err), 32'd0);
        check("areset_stall", stall_cnt, 32'd0);
        check("areset_ctl", 32'(ctl), 32'(CTL_FREEZE));
        idle_inputs();
        #2;
        reset_ni = 1'b1;
        #1;
        check("areset_run", 32'(ctl), 32'(CTL_RUN));

        // Reset in the middle of an LSU wait returns to RUN
        lsu_req = 1'b1;
        repeat (2) tick();
        reset_ni = 1'b0;
        #2;
        lsu_req = 1'b0;
        reset_ni = 1'b1;
        #1;
        check("midwait_run", 32'(ctl), 32'(CTL_RUN));
        check("midwait_stall", stall_cnt, 32'd0);
        tick();
        check("midwait_err", 32'(err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush/forwarding controller for the 5-stage RV32 pipeline (IF, ID, EX, MEM, WB).
- Drives the enable and flush inputs of every pipeline register, including the MEM/WB register's enable_i, plus the PC enable.
- Detects load-use hazards, branch/jump redirects and multi-cycle LSU accesses, and produces EX-stage forwarding selects.
- Tracks LSU wait time and stall cycles for error detection and performance monitoring.

Parameters:
- LSU_TIMEOUT, 64, maximum consecutive cycles in LSU_WAIT before declaring a bus error (range 2..65535).
- CNT_W, 32, width of the saturating stall-cycle counter.

Ports:
- clk_i  in  1  clock
- reset_ni  in  1  asynchronous active-low reset
- id_rs1_addr_i  in  5  rs1 of instruction in ID
- id_rs2_addr_i  in  5  rs2 of instruction in ID
- id_rs1_used_i  in  1  ID instruction reads rs1
- id_rs2_used_i  in  1  ID instruction reads rs2
- ex_rs1_addr_i  in  5  rs1 of instruction in EX
- ex_rs2_addr_i  in  5  rs2 of instruction in EX
- ex_rd_addr_i  in  5  rd of instruction in EX
- ex_rd_wren_i  in  1  EX instruction writes rd
- ex_is_load_i  in  1  EX instruction is a load
- ex_redirect_i  in  1  taken branch/jump resolved in EX
- mem_rd_addr_i  in  5  rd in MEM
- mem_rd_wren_i  in  1  MEM writes rd
- wb_rd_addr_i  in  5  rd in WB
- wb_rd_wren_i  in  1  WB writes rd
- lsu_req_i  in  1  MEM instruction is accessing the LSU this cycle
- lsu_ack_i  in  1  LSU access completes this cycle
- pc_en_o  out  1  PC update enable
- if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o  out  1 each  pipeline register enables
- if_id_flush_o, id_ex_flush_o  out  1 each  load NOP (32'h13) and clear wren in the next register
- fwd_a_sel_o, fwd_b_sel_o  out  2 each  EX operand source: 00 regfile, 01 MEM ALU result, 10 WB data
- err_o  out  1  sticky LSU timeout error
- stall_cnt_o  out  CNT_W  saturating count of cycles with pc_en_o=0

Behaviour:
- Reset (reset_ni=0, asynchronous):
  - State RUN, wait counter 0, err_o=0, stall_cnt_o=0.
  - While reset is asserted, all enables 0, flushes 0, fwd selects 00.
- State register encodes RUN, LSU_WAIT, ERROR. Enables and flushes are combinational from state and current inputs, taking effect at the same clock edge.
- Hazard match rule: register x0 never matches; a match requires the corresponding wren=1 (or used=1 on the ID side).
- Forwarding (combinational, independent of state): rs==mem_rd → 01; else rs==wb_rd → 10; else 00. MEM wins over WB when both match.
- RUN, evaluated in priority order; the first true condition applies:
  1. lsu_req_i=1 and lsu_ack_i=0: freeze. All enables 0, no flushes, next state LSU_WAIT, wait counter := 1.
  2. ex_redirect_i=1: all enables 1, if_id_flush_o=1, id_ex_flush_o=1. Redirect beats load-use.
  3. Load-use: ex_is_load_i and ex_rd_wren_i and (rs1 match with used, or rs2 match with used). pc_en_o=0, if_id_en_o=0, id_ex_en_o=1, id_ex_flush_o=1, ex_mem_en_o=1, mem_wb_en_o=1. Exactly one bubble per hazard.
  4. Otherwise: all enables 1, no flushes.
  - lsu_req_i=1 with lsu_ack_i=1 in RUN is a zero-wait access; fall through to rules 2-4.
- LSU_WAIT:
  - lsu_ack_i=1: enables and flushes evaluated as RUN rules 2-4 this cycle; next state RUN.
  - Else: full freeze; counter increments.
  - Counter reaching LSU_TIMEOUT without ack: next state ERROR.
  - ex_redirect_i is ignored while frozen; the branch remains in EX and is re-evaluated.
- ERROR: full freeze, err_o=1. Sticky until reset; all inputs ignored.
- stall_cnt_o increments on every clock edge where pc_en_o=0 (outside reset) and saturates at all-ones.
- Reset asserted mid-LSU_WAIT returns the block to RUN immediately; no pending state is kept.

Test Plan:
- Load x5 in EX, ID reads rs1=x5 → one cycle with pc_en_o=0, if_id_en_o=0, id_ex_flush_o=1; next cycle all enables 1; stall_cnt_o=1.
- Load with rd=x0 and ID rs1=x0, or ID rs1=x5 with used=0 → no stall.
- ex_redirect_i=1 coincident with a load-use condition → if_id_flush_o=id_ex_flush_o=1, pc_en_o=1, no stall.
- lsu_req_i held with ack after 3 wait cycles → 3 frozen cycles (all enables 0), release on the ack cycle, state RUN, stall_cnt_o=3; a redirect asserted during the wait is honoured only on the ack cycle.
- LSU_TIMEOUT=4, lsu_req_i held and never acked → ERROR after 4 cycles, err_o=1 sticky; async reset clears err_o, state and counters.
- mem_rd=wb_rd=x7 (both wren=1), ex_rs1=x7 → fwd_a_sel_o=01; MEM wren=0 → 10; rs1=x0 → 00.
